// File: rtl/contador_assincrono_crescente_4bit_pkg.sv
// Shared constants for the ripple up-counter.
package contador_assincrono_crescente_4bit_pkg;

  // Number of ripple stages (bits) in the counter.
  localparam int COUNT_WIDTH = 4;

endpackage

// File: rtl/contador_assincrono_crescente_4bit_t_flip_flop.sv
// Single toggle flip-flop stage: rising-edge triggered, asynchronous
// active-high clear. When t is high the stored bit inverts on each
// rising edge of its clock; when t is low it holds.
module t_flip_flop (
  input  logic clk,
  input  logic clear,
  input  logic t,
  output logic q
);

  // Toggle on rising clk when enabled; clear overrides everything.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/contador_assincrono_crescente_4bit.sv
// 4-bit asynchronous (ripple) up counter.
//
// Stage 0 is clocked by clk. Every later stage is clocked by the inverted
// output of the stage below it, so a 1->0 transition of q[i-1] is a rising
// edge for stage i. That falling-edge carry gives an up-count. Bits settle
// one flop delay apart (ripple skew), so q should be sampled well after the
// rising clk edge, e.g. on the following falling edge.
//
// The count enable T drives the toggle input of every stage, so with T=0
// no bit can change even if a lower bit is mid-transition. clear resets all
// stages at once without needing any clock.
module contador_assincrono_crescente_4bit
  import contador_assincrono_crescente_4bit_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             T,
  output logic [WIDTH-1:0] q
);

  // Per-stage clock: clk for stage 0, inverted previous bit for the rest.
  logic [WIDTH-1:0] stage_clk;

  assign stage_clk[0] = clk;

  genvar i;
  generate
    for (i = 1; i < WIDTH; i++) begin : g_carry
      assign stage_clk[i] = ~q[i-1];
    end

    for (i = 0; i < WIDTH; i++) begin : g_stage
      t_flip_flop u_tff (
        .clk   (stage_clk[i]),
        .clear (clear),
        .t     (T),
        .q     (q[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_contador_assincrono_crescente_4bit.sv
// Directed bench for the 4-bit ripple up counter. Clock period 20 ns,
// first rising edge at 10 ns; q is sampled on falling edges (half a period
// after each rising edge) so the ripple has settled.
module tb_contador_assincrono_crescente_4bit;

  localparam int W = 4;

  logic         clk;
  logic         clear;
  logic         T;
  logic [W-1:0] q;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  contador_assincrono_crescente_4bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .clear (clear),
    .T     (T),
    .q     (q)
  );

  // Clock and reset block: clk low at 0, rises at 10, 30, 50, ...
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Single comparison point: counts every check, reports mismatches.
  task automatic check_q(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and compare q to the head of exp_q.
  task automatic step_and_check(input string tag);
    logic [W-1:0] e;
    @(negedge clk);
    e = exp_q.pop_front();
    check_q(tag, q, e);
  endtask

  initial begin
    // Reset phase: clear=1, T=1 for 40 ns.
    clear = 1'b1;
    T     = 1'b1;
    #5;
    check_q("reset_t5", q, 4'd0);
    @(posedge clk); #1;
    check_q("reset_edge10", q, 4'd0);
    @(posedge clk); #1;
    check_q("reset_edge30", q, 4'd0);
    @(negedge clk);                       // t = 40 ns
    check_q("reset_t40", q, 4'd0);
    clear = 1'b0;

    // Count 1..15, then wrap to 0 and on to 1.
    for (int k = 1; k <= 15; k++) exp_q.push_back(k[W-1:0]);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    for (int k = 1; k <= 15; k++) begin
      if (k == 8) step_and_check("settle_7_to_8");
      else        step_and_check("count_up");
    end
    step_and_check("wrap_15_to_0");
    step_and_check("after_wrap");

    // Count up to 5.
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd4);
    exp_q.push_back(4'd5);
    repeat (4) step_and_check("count_to_5");

    // Hold: T=0 for three cycles, driven away from the rising edge.
    T = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_q("hold_at_5", q, 4'd5);
    end
    T = 1'b1;
    exp_q.push_back(4'd6);
    step_and_check("resume_6");

    // Count to 11 (1011).
    for (int k = 7; k <= 11; k++) exp_q.push_back(k[W-1:0]);
    repeat (5) step_and_check("count_to_11");

    // Asynchronous clear between edges: no rising edge until 7 ns later.
    #3;
    clear = 1'b1;
    #1;
    check_q("async_clear", q, 4'd0);
    // Hold clear across a rising edge.
    @(negedge clk);
    check_q("clear_over_edge", q, 4'd0);
    clear = 1'b0;
    exp_q.push_back(4'd1);
    step_and_check("after_clear_1");
    exp_q.push_back(4'd2);
    step_and_check("after_clear_2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
